// File: rtl/spdif_cs_pkg.sv
// Shared constants and types for the S/PDIF / AES3 channel status sequencer.
package spdif_cs_pkg;

    localparam int unsigned CS_BITS       = 192;
    localparam int unsigned CS_BYTES      = 24;
    localparam int unsigned IDX_W         = 8;
    localparam int unsigned LAST_IDX      = CS_BITS - 1;

    localparam logic [7:0]  CRC_POLY      = 8'h1D;
    localparam logic [7:0]  CRC_INIT      = 8'hFF;
    localparam int unsigned CRC_START_BIT = 184;

    localparam int unsigned CHNUM_LSB     = 20;
    localparam int unsigned CHNUM_MSB     = 23;
    localparam int unsigned PRO_BIT       = 0;

    typedef logic [IDX_W-1:0]   frame_idx_t;
    typedef logic [CS_BITS-1:0] cs_word_t;

    // Host byte-write payload into the shadow buffer
    typedef struct packed {
        logic [2:0] channel;
        logic [4:0] byte_idx;
        logic [7:0] data;
    } cs_wr_t;

endpackage

// File: rtl/spdif_cs_crc8.sv
// Bit-serial CRC-8 (x^8+x^4+x^3+x^2+1) with block init, per-frame enable and freeze.
module spdif_cs_crc8
    import spdif_cs_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init,
    input  logic       advance,
    input  logic       freeze,
    input  logic       din,
    output logic [7:0] crc_next_c
);

    logic [7:0] crc_q;
    logic       fb;

    // Init wins over advance; frozen while the CRCC byte is being emitted
    always_comb begin
        fb         = crc_q[7] ^ din;
        crc_next_c = crc_q;
        if (init) begin
            crc_next_c = CRC_INIT;
        end else if (advance && !freeze) begin
            crc_next_c = {crc_q[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_next_c;
        end
    end

endmodule

// File: rtl/spdif_channel_status_sequencer.sv
// Double-buffered channel status source: one C bit per channel per frame, block-atomic
// host updates, optional channel-number insertion and AES3 professional CRCC.
module spdif_channel_status_sequencer
    import spdif_cs_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS     = 2,
    parameter int unsigned AUTO_CHANNEL_NUM = 1,
    parameter int unsigned CRC_EN           = 1
) (
    input  logic                    clock,
    input  logic                    resetN,
    input  logic                    frameAdvance,
    input  logic                    restart,
    input  logic                    wrEn,
    input  logic [2:0]              wrChannel,
    input  logic [4:0]              wrByte,
    input  logic [7:0]              wrData,
    input  logic                    commit,
    output logic [NUM_CHANNELS-1:0] cBits,
    output logic                    blockStart,
    output logic [7:0]              frameIndex,
    output logic                    commitPending
);

    localparam frame_idx_t LAST_IDX_V = frame_idx_t'(LAST_IDX);

    cs_wr_t                       wr;
    frame_idx_t                   idx_d;
    logic                         boundary;
    logic                         swap;
    logic                         wr_ok;
    logic                         pending_d;
    logic                         crc_advance;
    logic                         crc_freeze;
    cs_word_t                     shadow_q [NUM_CHANNELS];
    cs_word_t                     shadow_d [NUM_CHANNELS];
    cs_word_t                     active_q [NUM_CHANNELS];
    cs_word_t                     active_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0][7:0] crc_d;
    logic [NUM_CHANNELS-1:0]      cbits_d;

    // Emitted bit: channel number overrides storage, CRCC overrides byte 23 in pro mode
    function automatic logic cs_bit(input int ch, input frame_idx_t idx,
                                    input cs_word_t word, input logic [7:0] crc);
        logic [3:0]  chnum;
        int unsigned pos;
        chnum = 4'(ch + 1);
        pos   = 32'(idx);
        if (AUTO_CHANNEL_NUM != 0 && pos >= CHNUM_LSB && pos <= CHNUM_MSB) begin
            return chnum[2'(pos - CHNUM_LSB)];
        end
        if (CRC_EN != 0 && word[PRO_BIT] && pos >= CRC_START_BIT) begin
            return crc[3'(LAST_IDX - pos)];
        end
        return word[idx];
    endfunction

    assign wr = {wrChannel, wrByte, wrData};

    always_comb begin
        wr_ok       = wrEn && (32'(wr.channel) < NUM_CHANNELS) && (32'(wr.byte_idx) < CS_BYTES);
        boundary    = restart || (frameAdvance && frameIndex == LAST_IDX_V);
        swap        = boundary && (commitPending || commit);
        pending_d   = !boundary && (commitPending || commit);
        crc_advance = frameAdvance && !restart;
        crc_freeze  = 32'(frameIndex) >= CRC_START_BIT;
        idx_d       = frameIndex;
        if (restart) begin
            idx_d = '0;
        end else if (frameAdvance) begin
            idx_d = (frameIndex == LAST_IDX_V) ? '0 : frameIndex + frame_idx_t'(1);
        end
    end

    // Next shadow includes this cycle's write so a same-cycle swap picks it up
    always_comb begin
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            shadow_d[ch] = shadow_q[ch];
            if (wr_ok && wr.channel == 3'(ch)) begin
                shadow_d[ch][{wr.byte_idx, 3'b000} +: 8] = wr.data;
            end
            active_d[ch] = swap ? shadow_d[ch] : active_q[ch];
            cbits_d[ch]  = cs_bit(ch, idx_d, active_d[ch], crc_d[ch]);
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        if (CRC_EN != 0) begin : g_crc
            spdif_cs_crc8 u_crc (
                .clk        (clock),
                .rst_n      (resetN),
                .init       (boundary),
                .advance    (crc_advance),
                .freeze     (crc_freeze),
                .din        (cBits[g]),
                .crc_next_c (crc_d[g])
            );
        end else begin : g_nocrc
            assign crc_d[g] = CRC_INIT;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            frameIndex    <= '0;
            blockStart    <= 1'b1;
            commitPending <= 1'b0;
            cBits         <= '0;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                shadow_q[ch] <= '0;
                active_q[ch] <= '0;
            end
        end else begin
            frameIndex    <= idx_d;
            blockStart    <= (idx_d == '0);
            commitPending <= pending_d;
            cBits         <= cbits_d;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                shadow_q[ch] <= shadow_d[ch];
                active_q[ch] <= active_d[ch];
            end
        end
    end

endmodule

// File: tb/tb_spdif_channel_status_sequencer.sv
// Randomized bench for the channel status sequencer against a byte-array reference model.
module tb_spdif_channel_status_sequencer;

    localparam int unsigned NCH = 2;

    logic           clock        = 1'b0;
    logic           resetN       = 1'b1;
    logic           frameAdvance = 1'b0;
    logic           restart      = 1'b0;
    logic           wrEn         = 1'b0;
    logic [2:0]     wrChannel    = '0;
    logic [4:0]     wrByte       = '0;
    logic [7:0]     wrData       = '0;
    logic           commit       = 1'b0;
    logic [NCH-1:0] cBits;
    logic           blockStart;
    logic [7:0]     frameIndex;
    logic           commitPending;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [7:0]  m_shadow [NCH][24];
    logic [7:0]  m_active [NCH][24];
    logic        m_pending;
    int unsigned m_idx;

    spdif_channel_status_sequencer #(
        .NUM_CHANNELS     (NCH),
        .AUTO_CHANNEL_NUM (1),
        .CRC_EN           (1)
    ) dut (
        .clock         (clock),
        .resetN        (resetN),
        .frameAdvance  (frameAdvance),
        .restart       (restart),
        .wrEn          (wrEn),
        .wrChannel     (wrChannel),
        .wrByte        (wrByte),
        .wrData        (wrData),
        .commit        (commit),
        .cBits         (cBits),
        .blockStart    (blockStart),
        .frameIndex    (frameIndex),
        .commitPending (commitPending)
    );

    always #5 clock = ~clock;

    // Active word as transmitted before the CRCC byte: stored bits with channel number inserted
    function automatic logic [191:0] word_of(int unsigned ch);
        logic [191:0] w;
        for (int i = 0; i < 192; i++) w[i] = m_active[ch][i / 8][i % 8];
        for (int n = 0; n < 4; n++) w[20 + n] = 1'((ch + 1) >> n);
        return w;
    endfunction

    function automatic logic [7:0] ref_crc(logic [191:0] bits, int unsigned n);
        logic [7:0] c;
        logic       fb;
        c = 8'hFF;
        for (int j = 0; j < int'(n); j++) begin
            fb = c[7] ^ bits[j];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h1D : 8'h00);
        end
        return c;
    endfunction

    function automatic logic exp_bit(int unsigned ch, int unsigned i);
        logic [191:0] w;
        logic [7:0]   c;
        w = word_of(ch);
        if (m_active[ch][0][0] && i >= 184) begin
            c = ref_crc(w, 184);
            return c[3'(191 - i)];
        end
        return w[i];
    endfunction

    function automatic logic [NCH+9:0] model_vec();
        logic [NCH-1:0] cb;
        for (int ch = 0; ch < NCH; ch++) cb[ch] = exp_bit(ch, m_idx);
        return {cb, m_idx == 0, m_idx[7:0], m_pending};
    endfunction

    function automatic logic [NCH+9:0] dut_vec();
        return {cBits, blockStart, frameIndex, commitPending};
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            for (int b = 0; b < 24; b++) begin
                m_shadow[ch][b] = 8'h00;
                m_active[ch][b] = 8'h00;
            end
        end
        m_pending = 1'b0;
        m_idx     = 0;
    endtask

    // One clock: drive at negedge, update model at posedge, return at next negedge
    task automatic step(input logic adv, input logic rs, input logic we, input logic [2:0] ch,
                        input logic [4:0] by, input logic [7:0] d, input logic cm);
        logic bnd;
        frameAdvance = adv; restart = rs; wrEn = we;
        wrChannel = ch; wrByte = by; wrData = d; commit = cm;
        @(posedge clock);
        bnd = rs || (adv && m_idx == 191);
        if (we && ch < NCH && by < 24) m_shadow[ch][by] = d;
        if (cm) m_pending = 1'b1;
        if (bnd && m_pending) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end
        if (rs) m_idx = 0;
        else if (adv) m_idx = (m_idx + 1) % 192;
        @(negedge clock);
        frameAdvance = 1'b0; restart = 1'b0; wrEn = 1'b0; commit = 1'b0;
    endtask

    task automatic write_byte(input int unsigned ch, input int unsigned b, input logic [7:0] d);
        step(1'b0, 1'b0, 1'b1, 3'(ch), 5'(b), d, 1'b0);
    endtask

    task automatic advance_to(input int unsigned target);
        int unsigned guard;
        guard = 0;
        do begin
            step(1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 8'd0, 1'b0);
            guard++;
        end while (m_idx != target && guard < 400);
    endtask

    // Idle cycle carrying a write to an out-of-range channel or byte
    task automatic idle_junk();
        logic [2:0] ch;
        logic [4:0] by;
        if ($urandom_range(0, 1) == 0) begin
            ch = 3'($urandom_range(NCH, 7));
            by = 5'($urandom_range(0, 31));
        end else begin
            ch = 3'($urandom_range(0, NCH - 1));
            by = 5'($urandom_range(24, 31));
        end
        step(1'b0, 1'b0, 1'b1, ch, by, 8'($urandom), 1'b0);
    endtask

    task automatic test_reset();
        @(negedge clock);
        resetN = 1'b0;
        @(negedge clock);
        model_reset();
        vectors++;
        if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL reset: got %h want %h", dut_vec(), model_vec());
        end
        resetN = 1'b1;
        @(negedge clock);
        vectors++;
        if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL reset_release: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_idle_block();
        for (int f = 0; f < 192; f++) begin
            if ($urandom_range(0, 2) == 0) begin
                idle_junk();
                vectors++;
                if (dut_vec() !== model_vec()) begin
                    miscompares++;
                    $display("FAIL idle_hold idx=%0d: got %h want %h", m_idx, dut_vec(), model_vec());
                end
            end
            step(1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 8'd0, 1'b0);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL idle_adv idx=%0d: got %h want %h", m_idx, dut_vec(), model_vec());
            end
        end
        vectors++;
        if (frameIndex !== 8'd0 || blockStart !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_wrap: got idx=%0d bs=%b want idx=0 bs=1", frameIndex, blockStart);
        end
    endtask

    task automatic test_commit_mid_block();
        for (int ch = 0; ch < NCH; ch++) begin
            write_byte(ch, 0, 8'h04);
            write_byte(ch, 3, 8'h02);
            write_byte(ch, $urandom_range(4, 19), 8'($urandom));
        end
        advance_to(50);
        step(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 8'd0, 1'b1);
        vectors++;
        if (commitPending !== 1'b1) begin
            miscompares++;
            $display("FAIL commit_pending: got %b want 1", commitPending);
        end
        for (int f = 0; f < 172; f++) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 8'd0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 8'd0, 1'b0);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL commit_mid idx=%0d: got %h want %h", m_idx, dut_vec(), model_vec());
            end
            if (f > 141 && (m_idx == 2 || m_idx == 25)) begin
                vectors++;
                if (cBits !== 2'b11) begin
                    miscompares++;
                    $display("FAIL new_word idx=%0d: got %b want 11", m_idx, cBits);
                end
            end
        end
    endtask

    task automatic test_commit_at_wrap();
        logic [7:0]  d;
        int unsigned wc;
        d  = 8'($urandom);
        wc = $urandom_range(0, NCH - 1);
        advance_to(191);
        step(1'b1, 1'b0, 1'b1, 3'(wc), 5'd1, d, 1'b1);
        vectors++;
        if (commitPending !== 1'b0 || frameIndex !== 8'd0) begin
            miscompares++;
            $display("FAIL wrap_commit: got pend=%b idx=%0d want pend=0 idx=0", commitPending, frameIndex);
        end
        for (int f = 0; f < 16; f++) begin
            step(1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 8'd0, 1'b0);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL wrap_block idx=%0d: got %h want %h", m_idx, dut_vec(), model_vec());
            end
            if (m_idx >= 8 && m_idx <= 15) begin
                vectors++;
                if (cBits[wc] !== d[3'(m_idx - 8)]) begin
                    miscompares++;
                    $display("FAIL wrap_byte1 idx=%0d: got %b want %b", m_idx, cBits[wc], d[3'(m_idx - 8)]);
                end
            end
        end
    endtask

    task automatic test_crc();
        logic [7:0]   b23 [NCH];
        logic [191:0] cap [NCH];
        logic [7:0]   d;
        for (int ch = 0; ch < NCH; ch++) begin
            for (int b = 0; b < 24; b++) begin
                d = (b == 0) ? 8'h01 : (b == 3) ? 8'h02 : 8'($urandom);
                if (b == 23) b23[ch] = d;
                write_byte(ch, b, d);
            end
        end
        step(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 8'd0, 1'b1);
        advance_to(0);
        for (int k = 0; k < 192; k++) begin
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL pro_block idx=%0d: got %h want %h", m_idx, dut_vec(), model_vec());
            end
            for (int ch = 0; ch < NCH; ch++) cap[ch][k] = cBits[ch];
            step(1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 8'd0, 1'b0);
        end
        for (int ch = 0; ch < NCH; ch++) begin
            vectors++;
            if (ref_crc(cap[ch], 192) !== 8'h00) begin
                miscompares++;
                $display("FAIL crc_residue ch=%0d: got %h want 00", ch, ref_crc(cap[ch], 192));
            end
        end
        for (int ch = 0; ch < NCH; ch++) write_byte(ch, 0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 8'd0, 1'b1);
        advance_to(0);
        for (int k = 0; k < 192; k++) begin
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL consumer_block idx=%0d: got %h want %h", m_idx, dut_vec(), model_vec());
            end
            if (k >= 184) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    vectors++;
                    if (cBits[ch] !== b23[ch][3'(k - 184)]) begin
                        miscompares++;
                        $display("FAIL consumer_b23 ch=%0d idx=%0d: got %b want %b",
                                 ch, k, cBits[ch], b23[ch][3'(k - 184)]);
                    end
                end
            end
            step(1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 8'd0, 1'b0);
        end
    endtask

    task automatic test_restart();
        logic [191:0] cap [NCH];
        for (int ch = 0; ch < NCH; ch++) begin
            write_byte(ch, 0, 8'h01);
            write_byte(ch, $urandom_range(4, 19), 8'($urandom));
        end
        advance_to(100);
        step(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 8'd0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 3'd0, 5'd0, 8'd0, 1'b0);
        vectors++;
        if (frameIndex !== 8'd0 || commitPending !== 1'b0 || blockStart !== 1'b1) begin
            miscompares++;
            $display("FAIL restart: got idx=%0d pend=%b bs=%b want idx=0 pend=0 bs=1",
                     frameIndex, commitPending, blockStart);
        end
        for (int k = 0; k < 192; k++) begin
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL restart_block idx=%0d: got %h want %h", m_idx, dut_vec(), model_vec());
            end
            for (int ch = 0; ch < NCH; ch++) cap[ch][k] = cBits[ch];
            if ($urandom_range(0, 4) == 0) step(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 8'd0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 8'd0, 1'b0);
        end
        for (int ch = 0; ch < NCH; ch++) begin
            vectors++;
            if (ref_crc(cap[ch], 192) !== 8'h00) begin
                miscompares++;
                $display("FAIL restart_crc ch=%0d: got %h want 00", ch, ref_crc(cap[ch], 192));
            end
        end
    endtask

    task automatic test_reset_mid_block();
        write_byte($urandom_range(0, NCH - 1), $urandom_range(4, 19), 8'($urandom_range(1, 255)));
        advance_to(120);
        step(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 8'd0, 1'b1);
        #1 resetN = 1'b0;
        #1;
        vectors++;
        if (dut_vec() !== {2'b00, 1'b1, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: got %h want %h", dut_vec(), {2'b00, 1'b1, 8'h00, 1'b0});
        end
        model_reset();
        @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
        step(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 8'd0, 1'b1);
        for (int f = 0; f < 200; f++) begin
            step(1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 8'd0, 1'b0);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL post_reset idx=%0d: got %h want %h", m_idx, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle_block();
        test_commit_mid_block();
        test_commit_at_wrap();
        test_crc();
        test_restart();
        test_reset_mid_block();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spdif_channel_status_sequencer.md
Name: spdif_channel_status_sequencer

Overview:
Parametrised, double-buffered Channel Status (IEC 60958-1/-3, AES3) source for an S/PDIF or HDMI audio transmitter.
- Holds one 192-bit status word per channel and emits one C bit per channel per frame, with a block-start flag.
- Host updates are staged in a shadow buffer and swapped in atomically only at a block boundary, so a 192-frame block is never mixed.
- Optionally inserts the per-channel Channel Number field and the AES3 professional CRCC byte (byte 23).

Parameters:
NUM_CHANNELS, 2, audio channels (subframes per frame), 1..8
AUTO_CHANNEL_NUM, 1, when 1, bits 23:20 of channel k are forced to k+1
CRC_EN, 1, when 1 and active word bit 0 = 1 (professional), bits 184..191 carry CRCC

Ports:
clock  in  1  single clock
resetN  in  1  asynchronous active-low reset
frameAdvance  in  1  pulse: current frame consumed by the serializer, advance index
restart  in  1  synchronous pulse: force next frame index to 0
wrEn  in  1  shadow byte write strobe
wrChannel  in  3  channel select for write
wrByte  in  5  byte index 0..23 within the status word
wrData  in  8  byte value; bit n of byte b is status bit 8b+n
commit  in  1  pulse: request shadow to active swap at next block boundary
cBits  out  NUM_CHANNELS  C bit for each channel at current frameIndex
blockStart  out  1  high while frameIndex == 0 (drives B preamble / HDMI B flag)
frameIndex  out  8  current bit index 0..191
commitPending  out  1  swap requested and not yet performed

Behaviour:
- Reset (resetN low, async): frameIndex=0, blockStart=1, commitPending=0, shadow and active buffers all zero, CRC registers=8'hFF. cBits then reflects the all-zero word, plus the channel number field if AUTO_CHANNEL_NUM=1.
- Frame counter: on frameAdvance, frameIndex increments. 191 wraps to 0; this wrap is the block boundary. cBits, blockStart and frameIndex update in the cycle after frameAdvance.
- cBits is a function of registered state only. There is no combinational path from any input to any output.
- restart: next frameIndex=0, treated as a block boundary (swap, CRC reinit). It has priority over frameAdvance in the same cycle.
- Writes: wrEn writes wrData into shadow[wrChannel][wrByte] at the clock edge. wrChannel>=NUM_CHANNELS or wrByte>23 is ignored. Writes are allowed at any time, including while commitPending=1.
- commit: sets commitPending. Repeated commit while pending has no extra effect.
- Swap: at a block boundary with commitPending=1 (including one set by commit in the same cycle), active <= shadow, including any write in that same cycle. commitPending then clears.
- Channel number: with AUTO_CHANNEL_NUM=1, output bits 20..23 of channel k are the 4-bit value k+1, LSB at bit 20. Stored bits are ignored. The CRC covers the substituted values.
- CRC engine (per channel, only when CRC_EN=1):
  - Register c[7:0], initialised to 8'hFF at each block boundary.
  - For bits 0..183, on each frameAdvance: fb = c[7] ^ bit; c = {c[6:0],1'b0} ^ (fb ? 8'h1D : 8'h00). Polynomial is x^8+x^4+x^3+x^2+1.
  - For frameIndex 184+k (k=0..7), when active bit 0 = 1, the output C bit is c[7-k] and c is frozen.
  - When active bit 0 = 0, bits 184..191 come from stored byte 23.
- Stored bits are used directly in all other cases.
- Mid-block resetN assertion: immediate return to reset state, with no partial swap.

Decomposition:
- Package spdif_cs_pkg:
  - CS_BITS=192, CS_BYTES=24
  - CRC_POLY=8'h1D, CRC_INIT=8'hFF, CRC_START_BIT=184
  - CHNUM_LSB=20, CHNUM_MSB=23, PRO_BIT=0
  - 8-bit frame index typedef
- Sub-module spdif_cs_crc8: bit-serial CRC-8 with init, enable and freeze. One instance per channel via generate.

Test Plan:
- Reset, then 192 frameAdvance pulses with NUM_CHANNELS=2, AUTO_CHANNEL_NUM=1 -> blockStart high only at index 0; cBits all 0 except ch0 bit 20=1 and ch1 bit 21=1; frameIndex wraps 191->0.
- Write byte 0=8'h04 and byte 3=8'h02 to both channels, commit at frameIndex 50 -> commitPending=1 until the wrap; old word through index 191; new word from index 0 (bit 2=1, bit 25=1).
- commit and wrap in the same cycle, with a wrEn to byte 1 in that cycle -> swap occurs at that boundary and includes the written byte; commitPending stays 0 afterwards.
- Professional word (byte 0=8'h01, byte 3=8'h02), CRC_EN=1, one block -> a reference CRC run over all 192 captured bits of each channel yields 8'h00; stored byte 23 is ignored. Same word with byte 0=8'h00 -> bits 184..191 equal stored byte 23.
- restart at frameIndex 100 with commitPending=1 -> frameIndex=0 next cycle, swap done, CRC reinitialised to 8'hFF.
- resetN pulsed low at frameIndex 120 with commitPending=1 -> all outputs at reset values immediately (asynchronously), commitPending=0, no swap.
